grey_arb: RTL and testbench
===========================

# grey_arb

Round-robin arbiter and sequencer that shares one binary-to-Gray converter between two requesters. Each requester offers a WIDTH-bit binary word over a valid/ready handshake. The block grants one requester at a time, captures its word, and drives it through the converter. The registered Gray result is presented downstream with the requester id and a wrapping transaction sequence number, and is held until the consumer accepts it.

## Interface
- WIDTH, 8, width of binary input and Gray output words

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WIDTH  requester 0 binary word
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WIDTH  requester 1 binary word
- req1_ready  out  1  requester 1 word accepted this cycle
- out_valid  out  1  Gray result available
- out_grey  out  WIDTH  Gray-coded result
- out_id  out  1  requester that produced out_grey
- out_seq  out  8  transaction number of the current result
- out_ready  in  1  consumer accepts the result
- busy  out  1  FSM not in IDLE

## Operation
- Conversion: grey = bin ^ (bin >> 1), computed unsigned at WIDTH bits. The MSB passes through unchanged.
- FSM states:
  - IDLE: if either reqN_valid is high, grant one requester; go to CONV. Otherwise stay.
  - CONV: load out_grey and out_id; set out_valid; go to HOLD.
  - HOLD: stay while out_ready is low. On out_ready=1, clear out_valid, increment out_seq, go to IDLE.
- Grant rule:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - last_grant updates only on acceptance.
- reqN_ready is combinational. It is high only in IDLE, for the granted requester, and only while that requester's valid is high. It is never high for both requesters in the same cycle, and never high outside IDLE.
- The accepted data is captured into an internal WIDTH-bit register on the acceptance edge. Later changes on reqN_data have no effect on the result.
- out_seq is 8 bits and wraps 255 -> 0. It increments only on the out_valid & out_ready handshake.
- out_grey, out_id and out_seq are stable while out_valid is high.
- Reset values: state IDLE, out_valid 0, out_grey 0, out_id 0, out_seq 0, last_grant 1, captured data 0, busy 0.
- Reset asserted mid-transaction: the pending word or result is dropped with no handshake. Requesters must re-offer it.
- Requester valid dropping outside IDLE is legal. The requester is simply not granted.

## Timing
- Acceptance edge T (IDLE, reqN_valid & reqN_ready): state becomes CONV.
- Edge T+1: out_valid=1 and result registered, so the result is visible in the cycle after T+1.
- Latency from acceptance to out_valid is 2 clocks.
- If out_ready is already high when out_valid rises, the handshake completes at edge T+2, and IDLE can accept again in the cycle after T+2.
- Maximum throughput: one word per 3 clocks.
- out_ready is sampled only in HOLD. out_ready in IDLE or CONV is ignored.
- busy is registered and equals (state != IDLE).

## Structure
- Shared package grey_pkg holds:
  - the state encoding constants IDLE=2'd0, CONV=2'd1, HOLD=2'd2
  - the SEQ_W=8 constant
  - the requester id constants REQ0=1'b0, REQ1=1'b1
- Sub-module grey_conv: purely combinational WIDTH-bit binary-to-Gray converter, instanced once between the capture register and the output register.
- grey_arb contains the FSM, grant logic, capture register, output register and sequence counter.

## Test plan
- Single request: reset, req0_valid=1, data 8'h64, out_ready=1 -> req0_ready pulses 1 cycle; 2 clocks later out_valid=1, out_grey=8'h56, out_id=0, out_seq=0; out_seq reads 1 after the handshake.
- Contention: req0 8'h9B and req1 8'hFF both held valid -> grants alternate 0,1,0,1. Results are 8'hD6 (id 0) and 8'h80 (id 1), with out_seq 0,1,2,3.
- Backpressure: 8'h80 accepted with out_ready=0 for 5 cycles -> out_valid held, out_grey=8'hC0 stable, req0_ready/req1_ready stay 0, busy=1; out_ready=1 -> handshake, then IDLE.
- Sequence wrap: 256 transactions of 8'h00 -> out_grey=8'h00 each time; out_seq runs 255 then 0.
- Reset mid-operation: assert rst_n=0 in HOLD with out_valid=1 -> out_valid, out_grey, out_seq and busy drop to 0 immediately (asynchronously). After release, a contended request grants requester 0 first.
- Data change after accept: req1_data changes from 8'h01 to 8'hAA on the cycle after acceptance -> out_grey=8'h01, not 8'hFF.

Source files
------------

// File: rtl/grey_pkg.sv
// Shared types, constants and grant helper for the grey_arb arbiter/sequencer.
package grey_pkg;

    localparam int unsigned SEQ_W     = 8;
    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Round-robin pick: under contention the requester that did not win last time goes.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v1) begin
            g = REQ1;
        end else begin
            g = REQ0;
        end
        return g;
    endfunction

endpackage

// File: rtl/grey_conv.sv
// Purely combinational binary-to-Gray converter; the MSB passes through.
module grey_conv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] grey_o
);

    assign grey_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/grey_arb.sv
// Two-requester round-robin arbiter feeding one shared Gray converter, with a
// held, sequence-numbered result on a valid/ready output.
module grey_arb
    import grey_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_grey,
    output logic             out_id,
    output logic [SEQ_W-1:0] out_seq,
    input  logic             out_ready,
    output logic             busy
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   cap_data_q, cap_data_d;
    logic               cap_id_q, cap_id_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_grey_q, out_grey_d;
    logic               out_id_q, out_id_d;
    logic [SEQ_W-1:0]   out_seq_q, out_seq_d;
    logic               busy_q, busy_d;

    logic               grant_c;
    logic               accept_c;
    logic [WIDTH-1:0]   grey_c;

    // Single shared converter between the capture register and the output register.
    grey_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .bin_i  (cap_data_q),
        .grey_o (grey_c)
    );

    // Grant choice and combinational ready; only ever one ready, only in IDLE.
    always_comb begin
        grant_c    = pick_grant(req0_valid, req1_valid, last_grant_q);
        req0_ready = (state_q == IDLE) && req0_valid && (grant_c == REQ0);
        req1_ready = (state_q == IDLE) && req1_valid && (grant_c == REQ1);
        accept_c   = req0_ready || req1_ready;
    end

    // Next-state and register-update logic for the FSM and its datapath.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cap_data_d   = cap_data_q;
        cap_id_d     = cap_id_q;
        out_valid_d  = out_valid_q;
        out_grey_d   = out_grey_q;
        out_id_d     = out_id_q;
        out_seq_d    = out_seq_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cap_data_d   = (grant_c == REQ1) ? req1_data : req0_data;
                    cap_id_d     = grant_c;
                    last_grant_d = grant_c;
                    state_d      = CONV;
                end
            end
            CONV: begin
                out_grey_d  = grey_c;
                out_id_d    = cap_id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_seq_d   = out_seq_q + SEQ_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ1;
            cap_data_q   <= '0;
            cap_id_q     <= REQ0;
            out_valid_q  <= 1'b0;
            out_grey_q   <= '0;
            out_id_q     <= REQ0;
            out_seq_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cap_data_q   <= cap_data_d;
            cap_id_q     <= cap_id_d;
            out_valid_q  <= out_valid_d;
            out_grey_q   <= out_grey_d;
            out_id_q     <= out_id_d;
            out_seq_q    <= out_seq_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_grey  = out_grey_q;
    assign out_id    = out_id_q;
    assign out_seq   = out_seq_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_grey_arb.sv
// Self-checking bench for grey_arb: directed scenarios plus a randomized run,
// with a transaction-level reference model watching every cycle.
module tb_grey_arb;

    localparam int unsigned W     = 8;
    localparam int unsigned BOUND = 50;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_grey;
    logic         out_id;
    logic [7:0]   out_seq;
    logic         out_ready = 1'b0;
    logic         busy;

    int checks = 0;
    int errors = 0;

    grey_arb #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_grey   (out_grey),
        .out_id     (out_id),
        .out_seq    (out_seq),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Gray code from its definition: each bit is the XOR of neighbouring binary bits.
    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        for (int i = 0; i < int'(W); i++) begin
            g[i] = (i == int'(W) - 1) ? b[i] : (b[i] ^ b[i+1]);
        end
        return g;
    endfunction

    // Transaction-level model: one word in flight, its age in clocks, round-robin memory.
    bit           mon_en = 1'b0;
    bit           m_busy;
    int           m_age;
    logic [W-1:0] m_data;
    logic         m_id;
    logic         m_last;
    logic [7:0]   m_seq;
    int           m_accepts;

    task automatic model_init();
        m_busy = 1'b0;
        m_age  = 0;
        m_data = '0;
        m_id   = 1'b0;
        m_last = 1'b1;
        m_seq  = 8'd0;
    endtask

    // Compare every cycle against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit e_r0, e_r1, e_v;
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            e_v  = m_busy && (m_age >= 2);
            checks += 5;
            if (req0_ready !== e_r0) begin errors++; $display("FAIL mon_req0_ready: got %b want %b t=%0t", req0_ready, e_r0, $time); end
            if (req1_ready !== e_r1) begin errors++; $display("FAIL mon_req1_ready: got %b want %b t=%0t", req1_ready, e_r1, $time); end
            if (out_valid !== e_v)   begin errors++; $display("FAIL mon_out_valid: got %b want %b t=%0t", out_valid, e_v, $time); end
            if (busy !== m_busy)     begin errors++; $display("FAIL mon_busy: got %b want %b t=%0t", busy, m_busy, $time); end
            if (out_seq !== m_seq)   begin errors++; $display("FAIL mon_out_seq: got %0d want %0d t=%0t", out_seq, m_seq, $time); end
            if (e_v) begin
                checks += 2;
                if (out_grey !== to_gray(m_data)) begin errors++; $display("FAIL mon_out_grey: got %h want %h t=%0t", out_grey, to_gray(m_data), $time); end
                if (out_id !== m_id) begin errors++; $display("FAIL mon_out_id: got %b want %b t=%0t", out_id, m_id, $time); end
            end
            if (e_v && out_ready) begin
                m_busy = 1'b0;
                m_seq  = m_seq + 8'd1;
            end else if (e_r0 || e_r1) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_id   = e_r1;
                m_data = e_r1 ? req1_data : req0_data;
                m_last = e_r1;
                m_accepts++;
            end else if (m_busy && m_age < 2) begin
                m_age++;
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
    endtask

    // Reset with inputs quiet; leaves the bench aligned just after a rising edge.
    task automatic do_reset();
        mon_en = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_init();
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Advance to negedges until the selected condition holds (0:req0_ready 1:req1_ready 2:out_valid 3:any ready).
    task automatic wait_neg(input int which, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < int'(BOUND); k++) begin
            @(negedge clk);
            if ((which == 0 && req0_ready) || (which == 1 && req1_ready) ||
                (which == 2 && out_valid) || (which == 3 && (req0_ready || req1_ready))) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_grey !== 8'h00) begin errors++; $display("FAIL reset_out_grey: got %h want 00", out_grey); end
        if (out_id !== 1'b0)    begin errors++; $display("FAIL reset_out_id: got %b want 0", out_id); end
        if (out_seq !== 8'h00)  begin errors++; $display("FAIL reset_out_seq: got %0d want 0", out_seq); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h64; out_ready = 1'b1;
        wait_neg(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: got no req0_ready want 1"); end
        next_cycle();
        @(negedge clk);
        checks += 2;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_pulse: got %b want 0", req0_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL single_latency1: got %b want 0", out_valid); end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_grey !== 8'h56) begin errors++; $display("FAIL single_grey: got %h want 56", out_grey); end
        if (out_id !== 1'b0)    begin errors++; $display("FAIL single_id: got %b want 0", out_id); end
        if (out_seq !== 8'd0)   begin errors++; $display("FAIL single_seq: got %0d want 0", out_seq); end
        next_cycle();
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b want 0", out_valid); end
        if (out_seq !== 8'd1)   begin errors++; $display("FAIL single_seq_inc: got %0d want 1", out_seq); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_contention();
        bit ok;
        logic want_id;
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h9B;
        req1_valid = 1'b1; req1_data = 8'hFF;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want_id = logic'(i % 2);
            wait_neg(3, ok);
            checks++;
            if (!ok || req0_ready !== !want_id || req1_ready !== want_id) begin
                errors++; $display("FAIL contention_grant%0d: got r0=%b r1=%b want id %b", i, req0_ready, req1_ready, want_id);
            end
            next_cycle();
            wait_neg(2, ok);
            checks += 3;
            if (!ok || out_grey !== (want_id ? 8'h80 : 8'hD6)) begin errors++; $display("FAIL contention_grey%0d: got %h", i, out_grey); end
            if (out_id !== want_id)  begin errors++; $display("FAIL contention_id%0d: got %b want %b", i, out_id, want_id); end
            if (out_seq !== 8'(i))   begin errors++; $display("FAIL contention_seq%0d: got %0d want %0d", i, out_seq, i); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_backpressure();
        bit ok;
        req0_valid = 1'b1; req0_data = 8'h80; out_ready = 1'b0;
        wait_neg(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_accept: got no req0_ready want 1"); end
        next_cycle();
        req1_valid = 1'b1; req1_data = 8'h11;
        wait_neg(2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_valid_timeout: got no out_valid want 1"); end
        for (int j = 0; j < 5; j++) begin
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", j, out_valid); end
            if (out_grey !== 8'hC0) begin errors++; $display("FAIL bp_hold_grey%0d: got %h want c0", j, out_grey); end
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready%0d: got %b%b want 00", j, req0_ready, req1_ready); end
            if (busy !== 1'b1)      begin errors++; $display("FAIL bp_hold_busy%0d: got %b want 1", j, busy); end
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_before_hs: got %b want 1", out_valid); end
        next_cycle();
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL bp_after_hs_busy: got %b want 0", busy); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h00; out_ready = 1'b1;
        for (int t = 0; t < 256; t++) begin
            wait_neg(2, ok);
            checks += 2;
            if (!ok || out_grey !== 8'h00) begin errors++; $display("FAIL wrap_grey%0d: got %h want 00", t, out_grey); end
            if (out_seq !== 8'(t))         begin errors++; $display("FAIL wrap_seq%0d: got %0d want %0d", t, out_seq, t); end
            next_cycle();
            if (!ok) break;
        end
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_seq !== 8'd0) begin errors++; $display("FAIL wrap_seq_zero: got %0d want 0", out_seq); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        req1_valid = 1'b1; req1_data = 8'h05; out_ready = 1'b1;
        wait_neg(1, ok);
        next_cycle();
        req1_valid = 1'b0;
        wait_neg(2, ok);
        next_cycle();
        req0_valid = 1'b1; req0_data = 8'h80; out_ready = 1'b0;
        wait_neg(0, ok);
        next_cycle();
        req0_valid = 1'b0;
        wait_neg(2, ok);
        checks++;
        if (!ok || out_seq !== 8'd1) begin errors++; $display("FAIL rmid_setup: got valid=%b seq=%0d want 1/1", out_valid, out_seq); end
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        if (out_grey !== 8'h00) begin errors++; $display("FAIL rmid_grey: got %h want 00", out_grey); end
        if (out_seq !== 8'd0)   begin errors++; $display("FAIL rmid_seq: got %0d want 0", out_seq); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1;
        model_init();
        rst_n = 1'b1;
        mon_en = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h3C;
        req1_valid = 1'b1; req1_data = 8'hC3;
        out_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_first_grant: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
        next_cycle();
        idle_inputs();
        out_ready = 1'b1;
        repeat (4) next_cycle();
        idle_inputs();
    endtask

    task automatic test_data_change();
        bit ok;
        out_ready = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h01;
        wait_neg(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dchg_accept: got no req1_ready want 1"); end
        next_cycle();
        req1_valid = 1'b0; req1_data = 8'hAA;
        wait_neg(2, ok);
        checks += 2;
        if (!ok || out_grey !== 8'h01) begin errors++; $display("FAIL dchg_grey: got %h want 01", out_grey); end
        if (out_id !== 1'b1)           begin errors++; $display("FAIL dchg_id: got %b want 1", out_id); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        logic [7:0] seq0;
        int         acc0;
        seq0 = m_seq;
        acc0 = m_accepts;
        for (int c = 0; c < 600; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (6) next_cycle();
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0)      begin errors++; $display("FAIL rand_drain_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain_valid: got %b want 0", out_valid); end
        if (out_seq !== 8'(seq0 + 8'(m_accepts - acc0))) begin
            errors++; $display("FAIL rand_seq_total: got %0d want %0d", out_seq, 8'(seq0 + 8'(m_accepts - acc0)));
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        m_accepts = 0;
        model_init();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_data_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
